// File: rtl/mario_audio_out.sv
// Audio output stage: boxcar decimation, attenuation/mute, and a sample FIFO toward the serializer.
// Define MARIO_AUDIO_DCBLOCK_EN to insert a DC-blocking high-pass filter ahead of attenuation.
module mario_audio_out #(
  parameter int unsigned DECIM_LOG2 = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               I_CLK_48M,
  input  logic               I_RESETn,
  input  logic signed [15:0] I_SND_DAT,
  input  logic [2:0]         I_VOL,
  input  logic               I_MUTE,
  input  logic               I_SMP_READY,
  output logic signed [15:0] O_SMP_DAT,
  output logic               O_SMP_VALID,
  output logic               O_OVERFLOW
);

  localparam int unsigned ACC_W = 16 + DECIM_LOG2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DECIM_LOG2-1:0]    phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum_c;
  logic                     frame_end_c;
  logic signed [15:0]       s1;
  logic                     s1_valid;
  logic signed [15:0]       s2_src_c;
  logic signed [15:0]       s2_c;
  logic signed [15:0]       s2;
  logic                     s2_valid;

  // Running sum of the current frame
  always_comb begin
    sum_c       = acc + {{DECIM_LOG2{I_SND_DAT[15]}}, I_SND_DAT};
    frame_end_c = (phase == {DECIM_LOG2{1'b1}});
  end

  // The mean always fits 16 bits, so the shifted slice is the floor divide
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      phase    <= '0;
      acc      <= '0;
      s1       <= '0;
      s1_valid <= 1'b0;
    end else begin
      phase <= phase + DECIM_LOG2'(1);
      if (frame_end_c) begin
        s1       <= sum_c[DECIM_LOG2 +: 16];
        acc      <= '0;
        s1_valid <= 1'b1;
      end else begin
        acc      <= sum_c;
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef MARIO_AUDIO_DCBLOCK_EN
  logic signed [15:0] x_prev;
  logic signed [15:0] y_prev;
  logic signed [15:0] y_leak_c;
  logic signed [17:0] y_wide_c;

  // y = x - x_prev + y_prev - y_prev/256, saturated back to 16 bits
  always_comb begin
    y_leak_c = y_prev >>> 8;
    y_wide_c = {{2{s1[15]}}, s1} - {{2{x_prev[15]}}, x_prev}
             + {{2{y_prev[15]}}, y_prev} - {{2{y_leak_c[15]}}, y_leak_c};
    if (y_wide_c > 18'sd32767) begin
      s2_src_c = 16'sh7FFF;
    end else if (y_wide_c < -18'sd32768) begin
      s2_src_c = 16'sh8000;
    end else begin
      s2_src_c = y_wide_c[15:0];
    end
  end

  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (s1_valid) begin
      x_prev <= s1;
      y_prev <= s2_src_c;
    end
  end
`else
  always_comb begin
    s2_src_c = s1;
  end
`endif

  always_comb begin
    s2_c = I_MUTE ? 16'sd0 : (s2_src_c >>> I_VOL);
  end

  // Volume and mute are only captured on the frame's S2 edge
  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      s2       <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2 <= s2_c;
      end
    end
  end

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               pop_c;
  logic               full_c;
  logic               push_ok_c;
  logic               drop_c;
  logic [CNT_W-1:0]   cnt_next_c;
  logic [PTR_W-1:0]   rd_next_c;
  logic signed [15:0] head_c;

  // FIFO control; the next head bypasses storage when it is the word being written
  always_comb begin
    pop_c      = O_SMP_VALID && I_SMP_READY;
    full_c     = (count == CNT_W'(FIFO_DEPTH));
    push_ok_c  = s2_valid && (!full_c || pop_c);
    drop_c     = s2_valid && full_c && !pop_c;
    cnt_next_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    rd_next_c  = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    head_c     = (push_ok_c && (wr_ptr == rd_next_c)) ? s2 : mem[rd_next_c];
  end

  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      O_SMP_DAT   <= '0;
      O_SMP_VALID <= 1'b0;
      O_OVERFLOW  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr      <= rd_next_c;
      count       <= cnt_next_c;
      O_SMP_VALID <= (cnt_next_c != '0);
      if (cnt_next_c != '0) begin
        O_SMP_DAT <= head_c;
      end
      O_OVERFLOW <= O_OVERFLOW | drop_c;
    end
  end

endmodule

// File: tb/tb_mario_audio_out.sv
// Directed bench for mario_audio_out at default parameters (1024 clocks per sample, 4-entry FIFO).
module tb_mario_audio_out;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] snd;
  logic [2:0]         vol;
  logic               mute;
  logic               ready;
  logic signed [15:0] dat;
  logic               valid;
  logic               ovf;

  int checks;
  int failures;

  mario_audio_out dut (
    .I_CLK_48M   (clk),
    .I_RESETn    (rst_n),
    .I_SND_DAT   (snd),
    .I_VOL       (vol),
    .I_MUTE      (mute),
    .I_SMP_READY (ready),
    .O_SMP_DAT   (dat),
    .O_SMP_VALID (valid),
    .O_OVERFLOW  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After this returns, the next posedge is the first active edge (phase 0)
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    snd = 16'sd1234; vol = 3'd0; mute = 1'b0; ready = 1'b0;
    step(3);
    checks++;
    if (valid !== 1'b0 || dat !== 16'sd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%0b dat=%0d ovf=%0b want 0/0/0", valid, dat, ovf);
    end
  endtask

  task automatic test_constant();
    snd = 16'sd1000; vol = 3'd0; mute = 1'b0; ready = 1'b1;
    do_reset();
    step(1025);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL const_early valid=%0b want 0 after 1025 edges", valid);
    end
    step(1);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd1000) begin
      failures++;
      $display("FAIL const_first valid=%0b dat=%0d want 1/1000", valid, dat);
    end
    step(1);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL const_popped valid=%0b want 0", valid);
    end
    step(1023);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd1000) begin
      failures++;
      $display("FAIL const_second valid=%0b dat=%0d want 1/1000", valid, dat);
    end
    step(1);
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL const_after valid=%0b ovf=%0b want 0/0", valid, ovf);
    end
  endtask

  task automatic test_attenuation();
    snd = -16'sd8000; vol = 3'd3; mute = 1'b0; ready = 1'b0;
    do_reset();
    step(1026);
    checks++;
    if (valid !== 1'b1 || dat !== -16'sd1000) begin
      failures++;
      $display("FAIL atten_vol3 valid=%0b dat=%0d want 1/-1000", valid, dat);
    end
    mute = 1'b1; ready = 1'b1;
    step(1);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL atten_pop valid=%0b want 0", valid);
    end
    step(1023);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd0) begin
      failures++;
      $display("FAIL atten_mute valid=%0b dat=%0d want 1/0", valid, dat);
    end
    mute = 1'b0; vol = 3'd0; ready = 1'b0;
  endtask

  task automatic test_alternating();
    vol = 3'd0; mute = 1'b0; ready = 1'b0; snd = 16'sd2000;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      snd = (i % 2 == 0) ? 16'sd2000 : -16'sd1000;
      step(1);
    end
    snd = 16'sd0;
    step(2);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd500) begin
      failures++;
      $display("FAIL alt_mean valid=%0b dat=%0d want 1/500", valid, dat);
    end
    ready = 1'b1; step(1); ready = 1'b0;
    snd = 16'sd1024; step(1); snd = 16'sd0;
    step(1022);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd1) begin
      failures++;
      $display("FAIL spike_pos valid=%0b dat=%0d want 1/1", valid, dat);
    end
    ready = 1'b1; step(1); ready = 1'b0;
    snd = -16'sd1; step(1); snd = 16'sd0;
    step(1022);
    checks++;
    if (valid !== 1'b1 || dat !== -16'sd1) begin
      failures++;
      $display("FAIL spike_neg_floor valid=%0b dat=%0d want 1/-1", valid, dat);
    end
  endtask

  task automatic test_overflow();
    vol = 3'd0; mute = 1'b0; ready = 1'b0; snd = 16'sd1;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      snd = 16'(n + 1);
      step(1024);
    end
    snd = 16'sd5;
    step(2);
    checks++;
    if (ovf !== 1'b0 || valid !== 1'b1 || dat !== 16'sd1) begin
      failures++;
      $display("FAIL ovf_fourth ovf=%0b valid=%0b dat=%0d want 0/1/1", ovf, valid, dat);
    end
    step(1022);
    snd = 16'sd6;
    step(2);
    checks++;
    if (ovf !== 1'b1 || dat !== 16'sd1) begin
      failures++;
      $display("FAIL ovf_fifth ovf=%0b dat=%0d want 1/1", ovf, dat);
    end
    step(1024);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (valid !== 1'b1 || dat !== 16'(k)) begin
        failures++;
        $display("FAIL ovf_drain%0d valid=%0b dat=%0d want 1/%0d", k, valid, dat, k);
      end
      step(1);
    end
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty valid=%0b ovf=%0b want 0/1", valid, ovf);
    end
    ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    vol = 3'd0; mute = 1'b0; ready = 1'b0; snd = 16'sd1;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      snd = 16'(n + 1);
      step(1024);
    end
    snd = 16'sd5;
    step(2);
    checks++;
    if (ovf !== 1'b0 || valid !== 1'b1 || dat !== 16'sd1) begin
      failures++;
      $display("FAIL ppf_full ovf=%0b valid=%0b dat=%0d want 0/1/1", ovf, valid, dat);
    end
    step(1023);
    ready = 1'b1;
    step(1);
    checks++;
    if (ovf !== 1'b0 || dat !== 16'sd2) begin
      failures++;
      $display("FAIL ppf_same_cycle ovf=%0b dat=%0d want 0/2", ovf, dat);
    end
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (valid !== 1'b1 || dat !== 16'(k)) begin
        failures++;
        $display("FAIL ppf_drain%0d valid=%0b dat=%0d want 1/%0d", k, valid, dat, k);
      end
      step(1);
    end
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ppf_empty valid=%0b ovf=%0b want 0/0", valid, ovf);
    end
    ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    vol = 3'd0; mute = 1'b0; ready = 1'b0; snd = 16'sd7;
    do_reset();
    step(2049);
    checks++;
    if (valid !== 1'b1 || dat !== 16'sd7) begin
      failures++;
      $display("FAIL mrst_before valid=%0b dat=%0d want 1/7", valid, dat);
    end
    step(499);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || ovf !== 1'b0 || dat !== 16'sd0) begin
      failures++;
      $display("FAIL mrst_async valid=%0b ovf=%0b dat=%0d want 0/0/0", valid, ovf, dat);
    end
    snd = -16'sd3;
    step(2);
    rst_n = 1'b1;
    step(1025);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL mrst_early valid=%0b want 0", valid);
    end
    step(1);
    checks++;
    if (valid !== 1'b1 || dat !== -16'sd3) begin
      failures++;
      $display("FAIL mrst_after valid=%0b dat=%0d want 1/-3", valid, dat);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    snd      = 16'sd0;
    vol      = 3'd0;
    mute     = 1'b0;
    ready    = 1'b0;
    test_reset();
    test_constant();
    test_attenuation();
    test_alternating();
    test_overflow();
    test_push_pop_full();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
